ram2_arbiter: RTL and testbench

Controller that shares the single Ram2 SRAM port between two requesters: the instruction-fetch path and a data port used by the MEM stage for loads and stores into instruction space. Fetch owns the SRAM by default. A data-port request takes priority, stalls fetch, and runs a fixed read cycle or a three-phase write with a clean WE pulse. The block sits between the CPU pipeline and the Ram2 pins, replacing direct pin control by the instruction memory.

---
 rtl/ram2_arbiter.sv | 123 ++++++++++++
 tb/tb_ram2_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram2_arbiter.sv
// ram2_arbiter: shares the single Ram2 SRAM port between instruction fetch
// and a MEM-stage data port. Fetch owns the SRAM in IDLE. A data request
// stalls fetch and runs either a one-cycle read or a three-phase write
// (setup / WE-low pulse / hold), then returns a one-cycle DmAck pulse.
module ram2_arbiter #(
  parameter logic [15:0] NOP_INS = 16'h0800,
  parameter logic [1:0]  ADDR_HI = 2'b00
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] IfAddr,
  output logic [15:0] IfIns,
  output logic        IfStall,
  input  logic        DmReq,
  input  logic        DmWe,
  input  logic [15:0] DmAddr,
  input  logic [15:0] DmWData,
  output logic [15:0] DmRData,
  output logic        DmAck,
  output logic        Ram2_EN,
  output logic        Ram2_OE,
  output logic        Ram2_WE,
  output logic [17:0] Ram2_address,
  inout  logic [15:0] Ram2_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WSETUP,
    S_WPULSE,
    S_WHOLD
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q,  addr_d;
  logic [15:0] data_q,  data_d;
  logic [15:0] rdata_q, rdata_d;
  logic        we_q,    we_d;
  logic        ack_q,   ack_d;
  logic        oe_q,    oe_d;
  logic        wen_q,   wen_d;
  logic        drv_q,   drv_d;
  logic        accept;

  // A request is taken only in IDLE and never in the ack cycle, so a
  // requester that is still holding DmReq there is not served twice.
  assign accept = (state_q == S_IDLE) && DmReq && !ack_q;

  // Next-state, request latching and registered pin decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = DmAddr;
          data_d  = DmWData;
          we_d    = DmWe;
          state_d = DmWe ? S_WSETUP : S_RD;
        end
      end
      S_RD: begin
        rdata_d = Ram2_data;
        ack_d   = 1'b1;
        state_d = S_IDLE;
      end
      S_WSETUP: state_d = S_WPULSE;
      S_WPULSE: state_d = S_WHOLD;
      S_WHOLD: begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Pin controls are decoded from the next state and registered, so they
    // change exactly at the state boundary and are glitch-free; the bus is
    // driven in every non-IDLE state of a write transaction.
    drv_d = (state_d != S_IDLE) && we_d;
    oe_d  = drv_d;
    wen_d = (state_d != S_WPULSE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      wen_q   <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      wen_q   <= wen_d;
      drv_q   <= drv_d;
    end
  end

  assign IfStall      = (state_q != S_IDLE) || (DmReq && !ack_q);
  assign IfIns        = IfStall ? NOP_INS : Ram2_data;
  assign Ram2_address = {ADDR_HI, (state_q == S_IDLE) ? IfAddr : addr_q};
  assign Ram2_data    = drv_q ? data_q : 'z;
  assign Ram2_EN      = 1'b0;
  assign Ram2_OE      = oe_q;
  assign Ram2_WE      = wen_q;
  assign DmAck        = ack_q;
  assign DmRData      = rdata_q;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed bench for ram2_arbiter with an SRAM model and an ack scoreboard.
module tb_ram2_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        dm_req, dm_we;
  logic [15:0] if_ins, dm_rdata;
  logic        if_stall, dm_ack, ram2_en, ram2_oe, ram2_we;
  logic [17:0] ram2_address;
  wire  [15:0] ram2_data;

  logic [15:0] hi_ins, hi_rdata;
  logic        hi_stall, hi_ack, hi_en, hi_oe, hi_we;
  logic [17:0] hi_address;
  wire  [15:0] hi_data;

  logic        pl_en;
  logic [17:0] pl_addr;
  logic [15:0] pl_data;
  logic [15:0] mem [0:262143];

  int n_checks = 0;
  int n_errs   = 0;
  int ack_cnt  = 0;
  int ack_base;

  typedef struct packed {
    logic        wr;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ram2_arbiter #(.NOP_INS(16'h0800), .ADDR_HI(2'b00)) u_dut (
    .Clk(clk), .Rst(rst_n), .IfAddr(if_addr), .IfIns(if_ins), .IfStall(if_stall),
    .DmReq(dm_req), .DmWe(dm_we), .DmAddr(dm_addr), .DmWData(dm_wdata),
    .DmRData(dm_rdata), .DmAck(dm_ack), .Ram2_EN(ram2_en), .Ram2_OE(ram2_oe),
    .Ram2_WE(ram2_we), .Ram2_address(ram2_address), .Ram2_data(ram2_data)
  );

  ram2_arbiter #(.NOP_INS(16'h0800), .ADDR_HI(2'b01)) u_dut_hi (
    .Clk(clk), .Rst(rst_n), .IfAddr(if_addr), .IfIns(hi_ins), .IfStall(hi_stall),
    .DmReq(dm_req), .DmWe(dm_we), .DmAddr(dm_addr), .DmWData(dm_wdata),
    .DmRData(hi_rdata), .DmAck(hi_ack), .Ram2_EN(hi_en), .Ram2_OE(hi_oe),
    .Ram2_WE(hi_we), .Ram2_address(hi_address), .Ram2_data(hi_data)
  );

  // Asynchronous-read SRAM, written at the clock edge while WE is low.
  assign ram2_data = (!ram2_oe && !ram2_en) ? mem[ram2_address] : 16'hzzzz;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!ram2_we && !ram2_en) mem[ram2_address] <= ram2_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: every DmAck must match the oldest outstanding transaction.
  always @(negedge clk) begin
    exp_t e;
    if (dm_ack === 1'b1) begin
      ack_cnt++;
      chk("ack_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (!e.wr) chk("sb_rdata", dm_rdata, e.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    if_addr = 16'h0010; pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    // Reset with SRAM preload
    step(); pl_en = 1'b1; pl_addr = 18'h00010; pl_data = 16'h4901;
    step(); pl_addr = 18'h00200; pl_data = 16'hBEEF;
    step(); pl_addr = 18'h00300; pl_data = 16'h0000;
    step(); pl_en = 1'b0;
    smp();
    chk("rst_ack", dm_ack, 0);
    chk("rst_rdata", dm_rdata, 0);
    chk("rst_en", ram2_en, 0);
    chk("rst_oe", ram2_oe, 0);
    chk("rst_we", ram2_we, 1);
    chk("rst_stall_idle", if_stall, 0);
    step(); dm_req = 1'b1;
    smp();
    chk("rst_stall_follows_req", if_stall, 1);
    step(); dm_req = 1'b0; rst_n = 1'b1;
    smp();
    chk("idle_stall", if_stall, 0);
    chk("idle_ins", if_ins, 16'h4901);
    chk("idle_addr", ram2_address, 18'h00010);
    chk("idle_ack", dm_ack, 0);

    // Data read
    step(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200;
    exp_q.push_back('{wr: 1'b0, data: 16'hBEEF});
    smp();
    chk("rd_c0_stall", if_stall, 1);
    chk("rd_c0_ins", if_ins, 16'h0800);
    step();
    smp();
    chk("rd_c1_stall", if_stall, 1);
    chk("rd_c1_ins", if_ins, 16'h0800);
    chk("rd_c1_addr", ram2_address, 18'h00200);
    chk("rd_c1_oe", ram2_oe, 0);
    step(); dm_req = 1'b0;
    smp();
    chk("rd_c2_ack", dm_ack, 1);
    chk("rd_c2_rdata", dm_rdata, 16'hBEEF);
    chk("rd_c2_stall", if_stall, 0);
    chk("rd_c2_ins", if_ins, 16'h4901);

    // Data write; address and data change after accept are ignored
    step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'h1234;
    exp_q.push_back('{wr: 1'b1, data: 16'h1234});
    smp();
    chk("wr_c0_stall", if_stall, 1);
    step(); dm_wdata = 16'hFFFF; dm_addr = 16'h0555;
    smp();
    chk("wr_c1_we", ram2_we, 1);
    chk("wr_c1_oe", ram2_oe, 1);
    chk("wr_c1_bus", ram2_data, 16'h1234);
    chk("wr_c1_addr", ram2_address, 18'h00300);
    step();
    smp();
    chk("wr_c2_we", ram2_we, 0);
    chk("wr_c2_bus", ram2_data, 16'h1234);
    chk("wr_c2_addr", ram2_address, 18'h00300);
    step();
    smp();
    chk("wr_c3_we", ram2_we, 1);
    chk("wr_c3_bus", ram2_data, 16'h1234);
    chk("wr_c3_stall", if_stall, 1);
    chk("wr_c3_ack", dm_ack, 0);
    step(); dm_req = 1'b0; dm_we = 1'b0;
    smp();
    chk("wr_c4_ack", dm_ack, 1);
    chk("wr_c4_oe", ram2_oe, 0);
    chk("wr_c4_stall", if_stall, 0);
    step(); if_addr = 16'h0300;
    smp();
    chk("wr_fetch_back", if_ins, 16'h1234);

    // Held request: DmReq stays high through the ack cycle
    step(); if_addr = 16'h0010; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0010;
    exp_q.push_back('{wr: 1'b0, data: 16'h4901});
    ack_base = ack_cnt;
    step();
    step();
    smp();
    chk("held_ack", dm_ack, 1);
    chk("held_stall", if_stall, 0);
    step(); dm_req = 1'b0;
    smp();
    chk("held_no_reaccept", if_stall, 0);
    repeat (4) step();
    smp();
    chk("held_one_ack", ack_cnt - ack_base, 1);

    // Reset while in WPULSE
    ack_base = ack_cnt;
    step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0400; dm_wdata = 16'hAAAA;
    step();
    step(); rst_n = 1'b0;
    smp();
    chk("mrst_in_pulse", ram2_we, 0);
    step();
    smp();
    chk("mrst_we", ram2_we, 1);
    chk("mrst_oe", ram2_oe, 0);
    chk("mrst_ack", dm_ack, 0);
    chk("mrst_idle_addr", ram2_address, 18'h00010);
    chk("mrst_stall_req1", if_stall, 1);
    step(); rst_n = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
    smp();
    chk("mrst_stall_req0", if_stall, 0);
    repeat (3) step();
    smp();
    chk("mrst_no_ack", ack_cnt - ack_base, 0);

    // Address wrap at 16'hFFFF, checked on both ADDR_HI settings
    step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'hFFFF; dm_wdata = 16'h5A5A;
    exp_q.push_back('{wr: 1'b1, data: 16'h5A5A});
    step();
    smp();
    chk("wrap_setup_hi", hi_address, 18'h1FFFF);
    chk("wrap_setup_lo", ram2_address, 18'h0FFFF);
    step();
    smp();
    chk("wrap_pulse_hi", hi_address, 18'h1FFFF);
    chk("wrap_pulse_we", hi_we, 0);
    step();
    smp();
    chk("wrap_hold_hi", hi_address, 18'h1FFFF);
    step(); dm_req = 1'b0; dm_we = 1'b0;
    smp();
    chk("wrap_ack_hi", hi_ack, 1);
    chk("wrap_ack", dm_ack, 1);

    repeat (3) step();
    smp();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
